fix_point_multiplier: RTL and testbench
=======================================

FIX_POINT_MULTIPLIER -- requirements
Module: fix_point_multiplier

Interface
REQ-001 SHALL have parameter Q, default 13, number of fractional bits.
REQ-002 SHALL have parameter N, default 16, total word width: bit N-1 is the sign, bits N-2:0 are the magnitude (sign-magnitude); legal range 2 <= Q < N-1.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port a  input  N  multiplicand, sign-magnitude Q-format.
REQ-006 SHALL have port b  input  N  multiplier, sign-magnitude Q-format.
REQ-007 SHALL have port poke  input  1  start request; a and b are sampled on the same edge.
REQ-008 SHALL have port product  output  N  registered sign-magnitude result.
REQ-009 SHALL have port peek  output  1  one-cycle result-valid pulse.
REQ-010 SHALL have port overflow  output  1  saturation flag, qualified by and held with product.
REQ-011 SHALL have port busy  output  1  high while a multiply is in progress; poke is ignored while busy is high.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, MULT, DONE.
REQ-013 In IDLE or DONE, poke=1 at a rising edge SHALL capture a and b, clear the accumulator and bit counter, and enter MULT.
REQ-014 In DONE with poke=0, the FSM SHALL return to IDLE; in IDLE with poke=0, it SHALL stay in IDLE.
REQ-015 MULT SHALL run a shift-add over the N-1 magnitude bits of b, LSB first, processing one bit per cycle with a 2(N-1)-bit accumulator.
REQ-016 After the (N-1)th MULT edge, the FSM SHALL enter DONE, and product, overflow and peek SHALL be written on that same edge.
REQ-017 Latency: if poke is sampled at edge k, peek SHALL be high in the cycle after edge k+N-1, for exactly one cycle.
REQ-018 Back-to-back operation: a poke in the DONE cycle SHALL be accepted, giving one result every N cycles.
REQ-019 busy SHALL be 1 in MULT and 0 in IDLE and DONE.
REQ-020 poke asserted in MULT SHALL be ignored; it is not queued, and the captured operands are not disturbed.
REQ-021 Magnitude: full = |a|*|b| (2(N-1) bits); res = full >> Q, truncated toward zero.
REQ-022 If res >= 2^(N-1), the product magnitude SHALL saturate to all ones and overflow SHALL be 1; otherwise overflow SHALL be 0.
REQ-023 Sign SHALL be a[N-1] XOR b[N-1], except that a zero magnitude result SHALL have sign 0 (no negative zero).
REQ-024 product and overflow SHALL hold their values until the next DONE write; they SHALL NOT change during MULT.
REQ-025 Operand inputs SHALL be don't-care except at the capture edge.

Reset
REQ-026 rstn=0 SHALL immediately force: FSM=IDLE, product=0, peek=0, overflow=0, busy=0, accumulator=0, counter=0.
REQ-027 Reset asserted mid-MULT SHALL abort the operation, produce no peek, and leave the block ready to accept a poke on the first edge after rstn deasserts.

Verification
REQ-028 a=0x2000 (1.0), b=0x2000, poke pulse at edge k -> peek high after edge k+15 only; product=0x2000, overflow=0.
REQ-029 a=0x3000 (1.5), b=0xC000 (-2.0) -> product=0xE000 (-3.0), overflow=0.
REQ-030 a=0x6000 (3.0), b=0x4000 (2.0) -> product=0x7FFF, overflow=1; busy low in the DONE cycle.
REQ-031 a=0x8001, b=0x0001 (result underflows to 0) -> product=0x0000 (sign cleared), overflow=0.
REQ-032 poke held high continuously with new operands each DONE cycle -> a peek every 16 cycles, each product correct; operand changes during MULT have no effect.
REQ-033 rstn pulsed low 5 cycles after poke -> no peek, product=0, busy=0; a following poke of 0x2000*0x2000 -> 0x2000 with the standard latency.

Source files
------------

// File: rtl/fix_point_multiplier.sv
// Sequential sign-magnitude Q-format multiplier: one shift-add step per cycle over the
// N-1 magnitude bits of b, with a saturated, registered result and a one-cycle valid pulse.
module fix_point_multiplier #(
    parameter int Q = 13,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         poke,
    output logic [N-1:0] product,
    output logic         peek,
    output logic         overflow,
    output logic         busy
);

    localparam int AW = 2 * (N - 1);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   acc, acc_next, a_sh, res_full;
    logic [N-2:0]    b_sh, mag_nxt;
    logic [CW-1:0]   cnt;
    logic            sign_r, sign_nxt, ovf_nxt, start, last;

    assign start = poke && (state != MULT);
    assign last  = (state == MULT) && (cnt == CW'(N - 2));
    assign busy  = (state == MULT);

    // Final step is folded into the result so DONE and the result land on the same edge.
    assign acc_next = acc + (b_sh[0] ? a_sh : '0);
    assign res_full = acc_next >> Q;
    assign ovf_nxt  = |res_full[AW-1:N-1];
    assign mag_nxt  = ovf_nxt ? {(N-1){1'b1}} : res_full[N-2:0];
    assign sign_nxt = sign_r && (mag_nxt != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the default assignment ahead of the case keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? MULT : IDLE;
            MULT:       state_nxt = last ? DONE : MULT;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            sign_r   <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
            peek     <= 1'b0;
        end else begin
            peek <= 1'b0;
            if (start) begin
                acc    <= '0;
                a_sh   <= {{(N-1){1'b0}}, a[N-2:0]};
                b_sh   <= b[N-2:0];
                cnt    <= '0;
                sign_r <= a[N-1] ^ b[N-1];
            end else if (state == MULT) begin
                acc  <= acc_next;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    product  <= {sign_nxt, mag_nxt};
                    overflow <= ovf_nxt;
                    peek     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fix_point_multiplier.sv
// Self-checking bench for fix_point_multiplier: directed vector table, randomized
// operands against an arithmetic reference model, back-to-back and reset-abort sequences.
module tb_fix_point_multiplier;

    localparam int N = 16;
    localparam int Q = 13;

    logic         clk, rstn, poke;
    logic [N-1:0] a, b, product;
    logic         peek, overflow, busy;

    int checks = 0;
    int errors = 0;

    fix_point_multiplier #(.Q(Q), .N(N)) dut (
        .clk(clk), .rstn(rstn), .a(a), .b(b), .poke(poke),
        .product(product), .peek(peek), .overflow(overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] prod;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on magnitudes, then saturate and fix the sign.
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
        longint       full, res;
        logic [N-2:0] mag;
        logic         ovf, sgn;
        full = longint'(x[N-2:0]) * longint'(y[N-2:0]);
        res  = full / (longint'(1) << Q);
        ovf  = (res >= (longint'(1) << (N - 1)));
        mag  = ovf ? {(N-1){1'b1}} : res[N-2:0];
        sgn  = (x[N-1] ^ y[N-1]) && (mag != '0);
        return {ovf, sgn, mag};
    endfunction

    // Starts at a negedge; ends at a negedge with the FSM back in IDLE.
    task automatic run_op(input string name, input logic [N-1:0] xa, input logic [N-1:0] xb,
                          input logic [N-1:0] exp_p, input logic exp_o, input bit noisy);
        int           lat;
        bit           stable;
        logic [N-1:0] prev;
        a = xa; b = xb; poke = 1'b1;
        @(posedge clk);
        @(negedge clk);
        poke = noisy ? 1'($urandom()) : 1'b0;
        if (noisy) begin a = N'($urandom()); b = N'($urandom()); end
        check({name, " busy_in_mult"}, 32'(busy), 32'd1);
        prev   = product;
        stable = 1'b1;
        lat    = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (peek) begin lat = i; break; end
            if (product !== prev) stable = 1'b0;
            if (noisy) begin poke = 1'($urandom()); a = N'($urandom()); b = N'($urandom()); end
        end
        poke = 1'b0;
        check({name, " latency"},     32'(lat),      32'(N - 1));
        check({name, " product"},     32'(product),  32'(exp_p));
        check({name, " overflow"},    32'(overflow), 32'(exp_o));
        check({name, " busy_done"},   32'(busy),     32'd0);
        check({name, " hold_in_mult"}, 32'(stable),  32'd1);
        @(posedge clk);
        @(negedge clk);
        check({name, " peek_one_cycle"}, 32'(peek),  32'd0);
        check({name, " product_held"},   32'(product), 32'(exp_p));
    endtask

    vec_t         vecs[10];
    logic [N:0]   m;
    logic [N-1:0] cur_a, cur_b;
    int           nres, last_cyc, cyc, seen;

    initial begin
        vecs[0] = '{16'h2000, 16'h2000, 16'h2000, 1'b0};  // 1.0 * 1.0
        vecs[1] = '{16'h3000, 16'hC000, 16'hE000, 1'b0};  // 1.5 * -2.0
        vecs[2] = '{16'h6000, 16'h4000, 16'h7FFF, 1'b1};  // 3.0 * 2.0 saturates
        vecs[3] = '{16'h8001, 16'h0001, 16'h0000, 1'b0};  // underflow, no negative zero
        vecs[4] = '{16'h4000, 16'h4000, 16'h7FFF, 1'b1};  // exactly 2^(N-1): saturates
        vecs[5] = '{16'hFFFF, 16'h2000, 16'hFFFF, 1'b0};  // largest result that fits
        vecs[6] = '{16'hA000, 16'hA000, 16'h2000, 1'b0};  // -1.0 * -1.0
        vecs[7] = '{16'h2000, 16'h9000, 16'h9000, 1'b0};  // 1.0 * -0.5
        vecs[8] = '{16'h0000, 16'hD555, 16'h0000, 1'b0};  // zero operand
        vecs[9] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 1'b1};  // max * max

        rstn = 1'b0; poke = 1'b0; a = '0; b = '0;
        #1;
        check("reset product",  32'(product),  32'd0);
        check("reset peek",     32'(peek),     32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset busy",     32'(busy),     32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].ovf, 1'b0);

        for (int i = 0; i < 20; i++) begin
            cur_a = N'($urandom());
            cur_b = N'($urandom());
            m = model(cur_a, cur_b);
            run_op($sformatf("rand%0d", i), cur_a, cur_b, m[N-1:0], m[N], 1'b1);
        end

        // Back-to-back: poke held high, fresh operands presented only in DONE cycles.
        cur_a = 16'h3000; cur_b = 16'hC000;
        a = cur_a; b = cur_b; poke = 1'b1;
        nres = 0; last_cyc = 0; cyc = 0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (peek) begin
                m = model(cur_a, cur_b);
                check($sformatf("b2b%0d product", nres),  32'(product),  32'(m[N-1:0]));
                check($sformatf("b2b%0d overflow", nres), 32'(overflow), 32'(m[N]));
                if (nres > 0) check($sformatf("b2b%0d interval", nres), 32'(cyc - last_cyc), 32'(N));
                last_cyc = cyc;
                nres++;
                if (nres == 5) begin poke = 1'b0; break; end
                cur_a = N'($urandom()); cur_b = N'($urandom());
                a = cur_a; b = cur_b;
            end else begin
                a = N'($urandom()); b = N'($urandom());
            end
        end
        poke = 1'b0;
        check("b2b result count", 32'(nres), 32'd5);
        repeat (2) @(negedge clk);

        // Reset five cycles into a multiply: aborted, no peek, ready afterwards.
        a = 16'h6000; b = 16'h4000; poke = 1'b1;
        @(posedge clk);
        @(negedge clk);
        poke = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort product", 32'(product), 32'd0);
        check("abort busy",    32'(busy),    32'd0);
        check("abort peek",    32'(peek),    32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (peek) seen++;
        end
        check("abort no peek", 32'(seen), 32'd0);
        check("abort idle",    32'(busy), 32'd0);
        run_op("after_reset", 16'h2000, 16'h2000, 16'h2000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
